// File: rtl/sram_bist_master_pkg.sv
// Shared definitions for the SRAM BIST master.
//   - FSM state encodings (plain localparams)
//   - pattern_data(): expected data for a given address and pass
package sram_bist_master_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_FAIL    = 3'd6;

  // Pass 0 writes addr ^ seed, pass 1 writes the inverse. Computed at 32 bits;
  // callers truncate to their data width.
  function automatic logic [31:0] pattern_data(input logic [31:0] addr,
                                               input logic        pass_sel,
                                               input logic [31:0] seed);
    logic [31:0] base;
    base = addr ^ seed;
    return pass_sel ? ~base : base;
  endfunction

endpackage

// File: rtl/sram_bist_master_if.sv
// Host-port bundle between the BIST master and the SRAM controller.
//   req   master->slave  transaction request
//   we    master->slave  1 = write, 0 = read
//   addr  master->slave  transaction address
//   wdata master->slave  write data
//   ack   slave->master  1-cycle completion
//   rdata slave->master  read data, valid with ack on reads
interface sram_bist_master_if #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 8
);
  logic                 req;
  logic                 we;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] wdata;
  logic                 ack;
  logic [DATA_BITS-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_bist_master_watchdog.sv
// Ack watchdog: loadable down-counter with terminal-count expiry flag.
//   clk_sys  clock
//   rst_b    async active-low reset
//   load     reload the counter (one cycle before the request rises)
//   run      request outstanding; counter decrements while set
//   expired  counter has reached zero
module bist_watchdog #(
  parameter int TIMEOUT_BITS = 8
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic load,
  input  logic run,
  output logic expired
);
  // Loaded with 2**TIMEOUT_BITS-2 so that zero is reached in the
  // (2**TIMEOUT_BITS-1)th cycle of an unanswered request.
  localparam logic [TIMEOUT_BITS-1:0] LOAD_VAL = ~TIMEOUT_BITS'(1);

  logic [TIMEOUT_BITS-1:0] count;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);
endmodule

// File: rtl/sram_bist_master.sv
// SRAM BIST master: writes a seeded pattern over the whole address space, reads
// it back and compares, then repeats with the inverted pattern.
//   i_clk, i_rst_n   clock, async active-low reset
//   i_start          1-cycle start pulse (honoured in IDLE/DONE/FAIL only)
//   bus              host port towards the SRAM controller (master side)
//   o_busy/o_done/o_fail/o_timeout   status
//   o_fail_addr/o_fail_data          first failure record
//   o_led            status LED (off / slow blink / on / fast blink)
//
// state   | meaning
// IDLE    | after reset, waiting for i_start
// WR_REQ  | idle gap, launch write for addr
// WR_WAIT | write outstanding, waiting for ack
// RD_REQ  | idle gap, launch read for addr
// RD_WAIT | read outstanding, compare on ack
// DONE    | both passes clean
// FAIL    | miscompare or watchdog expiry
module sram_bist_master
  import sram_bist_master_pkg::*;
#(
  parameter int                   ADDR_BITS    = 20,
  parameter int                   DATA_BITS    = 8,
  parameter logic [DATA_BITS-1:0] SEED         = 8'hA5,
  parameter int                   TIMEOUT_BITS = 8,
  parameter int                   CBITS        = 26
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  sram_bist_master_if.master      bus,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_fail,
  output logic                    o_timeout,
  output logic [ADDR_BITS-1:0]    o_fail_addr,
  output logic [DATA_BITS-1:0]    o_fail_data,
  output logic                    o_led
);
  logic [2:0]           state;
  logic [ADDR_BITS-1:0] addr;
  logic                 pass_sel;
  logic [CBITS-1:0]     heartbeat;
  logic                 req;
  logic                 we;
  logic [DATA_BITS-1:0] wdata;
  logic [DATA_BITS-1:0] exp_data;
  logic                 addr_last;
  logic                 acked;
  logic                 wd_load;
  logic                 wd_expired;

  assign exp_data  = DATA_BITS'(pattern_data(32'(addr), pass_sel, 32'(SEED)));
  assign addr_last = (addr == '1);
  // i_ack outside a request is ignored.
  assign acked     = req && bus.ack;
  assign wd_load   = (state == ST_WR_REQ) || (state == ST_RD_REQ);

  bist_watchdog #(.TIMEOUT_BITS(TIMEOUT_BITS)) u_watchdog (
    .clk_sys (i_clk),
    .rst_b   (i_rst_n),
    .load    (wd_load),
    .run     (req),
    .expired (wd_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      addr        <= '0;
      pass_sel    <= 1'b0;
      heartbeat   <= '0;
      req         <= 1'b0;
      we          <= 1'b0;
      wdata       <= '0;
      o_done      <= 1'b0;
      o_fail      <= 1'b0;
      o_timeout   <= 1'b0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
    end else begin
      heartbeat <= heartbeat + 1'b1;
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (i_start) begin
            state       <= ST_WR_REQ;
            addr        <= '0;
            pass_sel    <= 1'b0;
            o_done      <= 1'b0;
            o_fail      <= 1'b0;
            o_timeout   <= 1'b0;
            o_fail_addr <= '0;
            o_fail_data <= '0;
          end
        end
        ST_WR_REQ: begin
          req   <= 1'b1;
          we    <= 1'b1;
          wdata <= exp_data;
          state <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (acked) begin
            req <= 1'b0;
            if (addr_last) begin
              addr  <= '0;
              state <= ST_RD_REQ;
            end else begin
              addr  <= addr + 1'b1;
              state <= ST_WR_REQ;
            end
          end else if (wd_expired) begin
            req         <= 1'b0;
            state       <= ST_FAIL;
            o_fail      <= 1'b1;
            o_timeout   <= 1'b1;
            o_fail_addr <= addr;
            o_fail_data <= '0;
          end
        end
        ST_RD_REQ: begin
          req   <= 1'b1;
          we    <= 1'b0;
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (acked) begin
            req <= 1'b0;
            if (bus.rdata != exp_data) begin
              state       <= ST_FAIL;
              o_fail      <= 1'b1;
              o_fail_addr <= addr;
              o_fail_data <= bus.rdata;
            end else if (!addr_last) begin
              addr  <= addr + 1'b1;
              state <= ST_RD_REQ;
            end else if (pass_sel) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              pass_sel <= 1'b1;
              addr     <= '0;
              state    <= ST_WR_REQ;
            end
          end else if (wd_expired) begin
            req         <= 1'b0;
            state       <= ST_FAIL;
            o_fail      <= 1'b1;
            o_timeout   <= 1'b1;
            o_fail_addr <= addr;
            o_fail_data <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req   = req;
  assign bus.we    = we;
  assign bus.addr  = addr;
  assign bus.wdata = wdata;

  assign o_busy = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_FAIL);

  always_comb begin
    o_led = 1'b0;
    case (state)
      ST_IDLE: o_led = 1'b0;
      ST_DONE: o_led = 1'b1;
      ST_FAIL: o_led = heartbeat[CBITS-3];
      default: o_led = heartbeat[CBITS-1];
    endcase
  end
endmodule

// File: tb/tb_sram_bist_master.sv
module tb_sram_bist_master;
  localparam int AB = 4;
  localparam int DB = 8;
  localparam int TB = 4;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail, timeout, led;
  logic [AB-1:0] fail_addr;
  logic [DB-1:0] fail_data;

  always #5 clk = ~clk;

  sram_bist_master_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  sram_bist_master #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .SEED(8'hA5), .TIMEOUT_BITS(TB), .CBITS(CB)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .bus         (bus),
    .o_busy      (busy),
    .o_done      (done),
    .o_fail      (fail),
    .o_timeout   (timeout),
    .o_fail_addr (fail_addr),
    .o_fail_data (fail_data),
    .o_led       (led)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard entry: {we, addr, wdata (0 for reads)}
  logic [12:0] sb[$];
  logic [7:0]  wr3_log[$];
  logic [7:0]  mem[16];
  int          xfers = 0;

  // responder controls
  int   lat_fixed = 1;
  bit   rand_lat = 0;
  bit   mute = 0;
  bit   spur_en = 0;
  bit   flip_pending = 0;

  function automatic logic [7:0] pat(input int a, input int p);
    logic [7:0] v;
    v = 8'(a) ^ 8'hA5;
    if (p != 0) v = ~v;
    return v;
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({bus.req, bus.we, bus.addr, bus.wdata, busy, done, fail, timeout,
                fail_addr, fail_data, led});
  endfunction

  task automatic push_run();
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 16; a++) sb.push_back({1'b1, 4'(a), pat(a, p)});
      for (int a = 0; a < 16; a++) sb.push_back({1'b0, 4'(a), 8'h00});
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && !(done || fail); i++) @(negedge clk);
    chk("end_reached", 32'(done || fail), 1);
  endtask

  // behavioural 16x8 responder, acts on the falling edge
  initial begin
    int          wait_cnt;
    int          cur_lat;
    bit          prev_req;
    logic [12:0] held;
    logic [12:0] obs;
    logic [12:0] e;
    wait_cnt = 0;
    cur_lat  = 1;
    prev_req = 0;
    held     = '0;
    bus.ack   = 1'b0;
    bus.rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      bus.ack = 1'b0;
      if (bus.req && prev_req)
        chk("req_stable", 32'({bus.we, bus.addr, bus.wdata}), 32'(held));
      held     = {bus.we, bus.addr, bus.wdata};
      prev_req = bus.req;
      if (bus.req && !mute) begin
        if (wait_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 6)) : lat_fixed;
        wait_cnt++;
        if (wait_cnt >= cur_lat) begin
          wait_cnt = 0;
          bus.ack  = 1'b1;
          obs = {bus.we, bus.addr, bus.we ? bus.wdata : 8'h00};
          if (sb.size() == 0) chk("sb_underflow", 0, 1);
          else begin
            e = sb.pop_front();
            chk("xfer", 32'(obs), 32'(e));
          end
          if (bus.we) begin
            mem[bus.addr] = bus.wdata;
            if (bus.addr == 4'd3) wr3_log.push_back(bus.wdata);
          end else begin
            bus.rdata = mem[bus.addr];
            if (flip_pending && bus.addr == 4'd9) begin
              bus.rdata = bus.rdata ^ 8'h08;
              flip_pending = 0;
            end
          end
          xfers++;
        end
      end else begin
        wait_cnt = 0;
        if (spur_en && !bus.req && $urandom_range(0, 3) == 0) bus.ack = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int hi_cnt;
    int toggles;
    logic last_led;

    // 1. reset state, then a clean run with 1-cycle ack latency
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    push_run();
    xfers = 0;
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    wait_end(2000);
    chk("t1_xfers", xfers, 64);
    chk("t1_done", 32'(done), 1);
    chk("t1_fail", 32'(fail), 0);
    chk("t1_led", 32'(led), 1);
    chk("t1_sb_left", sb.size(), 0);
    chk("t1_wr3_count", wr3_log.size(), 2);
    if (wr3_log.size() == 2) begin
      chk("t1_p0_wr3", 32'(wr3_log[0]), 32'h A6);
      chk("t1_p1_wr3", 32'(wr3_log[1]), 32'h 59);
    end

    // 2. corrupted read at addr 9 in pass 0
    sb.delete();
    push_run();
    xfers = 0;
    flip_pending = 1;
    pulse_start();
    wait_end(2000);
    chk("t2_fail", 32'(fail), 1);
    chk("t2_done", 32'(done), 0);
    chk("t2_timeout", 32'(timeout), 0);
    chk("t2_fail_addr", 32'(fail_addr), 32'h9);
    chk("t2_fail_data", 32'(fail_data), 32'hA4);
    chk("t2_xfers", xfers, 26);
    hi_cnt = 0;
    toggles = 0;
    last_led = led;
    repeat (20) begin
      @(negedge clk);
      if (bus.req) hi_cnt++;
      if (led != last_led) toggles++;
      last_led = led;
    end
    chk("t2_req_after_fail", hi_cnt, 0);
    chk("t2_fail_led_blinks", 32'(toggles > 0), 1);

    // 6. restart from FAIL, mid-run start ignored
    sb.delete();
    push_run();
    xfers = 0;
    pulse_start();
    chk("t6_fail_clr", 32'(fail), 0);
    chk("t6_fail_addr_clr", 32'(fail_addr), 0);
    chk("t6_fail_data_clr", 32'(fail_data), 0);
    chk("t6_busy", 32'(busy), 1);
    for (int i = 0; i < 10 && !bus.req; i++) @(negedge clk);
    chk("t6_first_req", 32'({bus.req, bus.we, bus.addr, bus.wdata}), 32'({1'b1, 1'b1, 4'h0, 8'hA5}));
    repeat (30) @(negedge clk);
    pulse_start();
    wait_end(2000);
    chk("t6_xfers", xfers, 64);
    chk("t6_done", 32'(done), 1);
    chk("t6_sb_left", sb.size(), 0);

    // 3. no ack at all: watchdog
    sb.delete();
    mute = 1;
    xfers = 0;
    pulse_start();
    hi_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.req) hi_cnt++;
      else if (hi_cnt > 0) break;
    end
    chk("t3_req_cycles", hi_cnt, 15);
    chk("t3_fail", 32'(fail), 1);
    chk("t3_timeout", 32'(timeout), 1);
    chk("t3_fail_addr", 32'(fail_addr), 0);
    chk("t3_fail_data", 32'(fail_data), 0);
    chk("t3_xfers", xfers, 0);
    mute = 0;

    // 4. random latency plus spurious acks
    rand_lat = 1;
    spur_en = 1;
    push_run();
    xfers = 0;
    pulse_start();
    wait_end(5000);
    chk("t4_xfers", xfers, 64);
    chk("t4_done", 32'(done), 1);
    chk("t4_sb_left", sb.size(), 0);
    rand_lat = 0;
    spur_en = 0;

    // 5. reset during a pass-1 read
    lat_fixed = 3;
    push_run();
    xfers = 0;
    pulse_start();
    for (int i = 0; i < 3000 && !(xfers >= 48 && bus.req && !bus.we); i++) @(negedge clk);
    chk("t5_in_p1_read", 32'(xfers >= 48 && bus.req && !bus.we), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_outs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    push_run();
    xfers = 0;
    pulse_start();
    wait_end(3000);
    chk("t5_xfers", xfers, 64);
    chk("t5_done", 32'(done), 1);
    chk("t5_sb_left", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
